maxpool_stream: RTL and testbench

Streaming, synthesizable successor to the file-based pooling dump stage. Accepts post-conv signed feature-map samples one per beat over a valid/ready handshake, channel by channel in raster order. Produces non-overlapping POOL×POOL max- or average-pooled outputs with a channel index and end-of-channel markers. Sits between a conv/bias stage and the next conv or dense stage in the fixed-point CIFAR-10 pipeline.

---
 rtl/maxpool_stream.sv | 158 +++++++++++++++
 tb/tb_maxpool_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL max/average pooling over raster-ordered channel maps.
// One sample in per beat; one registered pooled sample out per window.
module maxpool_stream #(
    parameter int DATA_W    = 25,
    parameter int WIDTH_IN  = 8,
    parameter int HEIGHT_IN = 8,
    parameter int CHANNELS  = 64,
    parameter int POOL      = 2,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    output logic                     frame_done
);

    localparam int WIDTH_OUT  = WIDTH_IN / POOL;
    localparam int HEIGHT_OUT = HEIGHT_IN / POOL;
    localparam int LP         = $clog2(POOL);
    localparam int SH         = 2 * LP;
    localparam int ACC_W      = DATA_W + SH;
    localparam int COL_W      = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1;
    localparam int ROW_W      = (HEIGHT_IN > 1) ? $clog2(HEIGHT_IN) : 1;
    localparam int IDX_W      = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1;

    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [CH_W-1:0]         r_ch;
    logic                    r_mode;
    logic signed [ACC_W-1:0] r_buf [1 << IDX_W];

    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]          r_out_ch;
    logic                     r_out_last;
    logic                     r_frame_done;

    logic                     w_fire;
    logic                     w_first;
    logic                     w_avg;
    logic [LP-1:0]            w_wc;
    logic [LP-1:0]            w_wr;
    logic                     w_in_win;
    logic [IDX_W-1:0]         w_idx;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  w_old;
    logic signed [ACC_W-1:0]  w_new;
    logic signed [DATA_W-1:0] w_res;
    logic                     w_emit;
    logic                     w_last_pos;
    logic                     w_take;
    logic                     w_col_end;
    logic                     w_row_end;
    logic                     w_ch_end;

    assign in_ready   = !(r_out_valid && !out_ready);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_ch     = r_out_ch;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;

    assign w_fire  = in_valid && in_ready;
    assign w_first = (r_col == '0) && (r_row == '0) && (r_ch == '0);
    // mode only takes effect on the first beat of a frame
    assign w_avg   = w_first ? mode : r_mode;

    assign w_wc     = r_col[LP-1:0];
    assign w_wr     = r_row[LP-1:0];
    assign w_in_win = (int'(r_col) < WIDTH_OUT * POOL) &&
                      (int'(r_row) < HEIGHT_OUT * POOL);
    assign w_idx    = IDX_W'(r_col >> LP);
    assign w_ext    = {{SH{in_data[DATA_W-1]}}, in_data};
    assign w_old    = r_buf[w_idx];

    always_comb begin
        w_new = w_old;
        if (w_wr == '0 && w_wc == '0) begin
            w_new = w_ext;
        end else if (w_avg) begin
            w_new = w_old + w_ext;
        end else if (w_ext > w_old) begin
            w_new = w_ext;
        end
    end

    assign w_res = w_avg ? DATA_W'(w_new >>> SH) : DATA_W'(w_new);

    assign w_emit     = w_fire && w_in_win && (&w_wr) && (&w_wc);
    assign w_last_pos = (int'(r_row) == HEIGHT_OUT * POOL - 1) &&
                        (int'(r_col) == WIDTH_OUT * POOL - 1);
    assign w_take     = r_out_valid && out_ready;

    assign w_col_end = (r_col == COL_W'(WIDTH_IN - 1));
    assign w_row_end = (r_row == ROW_W'(HEIGHT_IN - 1));
    assign w_ch_end  = (r_ch == CH_W'(CHANNELS - 1));

    always_ff @(posedge clk) begin
        if (w_fire && w_in_win) begin
            r_buf[w_idx] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_ch   <= '0;
            r_mode <= 1'b0;
        end else if (w_fire) begin
            if (w_first) begin
                r_mode <= mode;
            end
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_row <= '0;
                    r_ch  <= w_ch_end ? '0 : r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_take && r_out_last &&
                            (r_out_ch == CH_W'(CHANNELS - 1));
            // a new result may replace one leaving in the same cycle
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_ch    <= r_ch;
                r_out_last  <= w_last_pos;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: default 8x8x64 instance plus a 7x7x2
// instance exercising the discarded right/bottom remainder.
module tb_maxpool_stream;

    localparam int DW = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mode;

    logic                 a_in_valid, a_in_ready;
    logic signed [DW-1:0] a_in_data;
    logic                 a_out_valid, a_out_ready;
    logic signed [DW-1:0] a_out_data;
    logic [5:0]           a_out_ch;
    logic                 a_out_last, a_fd;

    logic                 b_in_valid, b_in_ready;
    logic signed [DW-1:0] b_in_data;
    logic                 b_out_valid, b_out_ready;
    logic signed [DW-1:0] b_out_data;
    logic [0:0]           b_out_ch;
    logic                 b_out_last, b_fd;

    maxpool_stream u_a (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_ch    (a_out_ch),
        .out_last  (a_out_last),
        .frame_done(a_fd)
    );

    maxpool_stream #(
        .WIDTH_IN (7),
        .HEIGHT_IN(7),
        .CHANNELS (2)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_ch    (b_out_ch),
        .out_last  (b_out_last),
        .frame_done(b_fd)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     stalls = 0;
    bit     bp_en = 1'b0;
    bit     chk_bp = 1'b0;
    bit     prev_hold = 1'b0;
    int     prev_data = 0;

    int     a_qd[$], a_qc[$], a_ql[$];
    int     b_qd[$], b_qc[$], b_ql[$];
    int     a_fd_cnt = 0, b_fd_cnt = 0;
    longint a_fd_cyc = -1, a_last_hs = -10;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            a_qd.push_back(a_out_data);
            a_qc.push_back(int'(a_out_ch));
            a_ql.push_back(int'(a_out_last));
            if (a_out_last && a_out_ch == 6'd63) a_last_hs = cyc;
        end
        if (!rst && b_out_valid && b_out_ready) begin
            b_qd.push_back(b_out_data);
            b_qc.push_back(int'(b_out_ch));
            b_ql.push_back(int'(b_out_last));
        end
        if (a_fd) begin
            a_fd_cnt++;
            a_fd_cyc = cyc;
        end
        if (b_fd) b_fd_cnt++;
        if (chk_bp && !rst) begin
            check("in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
            if (prev_hold) begin
                check("hold_valid", a_out_valid, 1);
                check("hold_data", a_out_data, prev_data);
            end
            prev_hold = a_out_valid && !a_out_ready;
            prev_data = a_out_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic send(input bit sel, input int d);
        int  n;
        bit  rdy;
        n = 0;
        if (sel) begin
            b_in_valid = 1'b1;
            b_in_data  = DW'(d);
        end else begin
            a_in_valid = 1'b1;
            a_in_data  = DW'(d);
        end
        forever begin
            @(negedge clk);
            rdy = sel ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            stalls++;
            n++;
            if (n > 1000) begin
                check("stall_timeout", n, 0);
                break;
            end
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    function automatic int pix_a(int kind, int c, int r, int k);
        int g;
        g = c * 100 + r * 8 + k;
        if (kind == 1) begin
            if (c == 0 && r < 2 && k < 2) return (r == 0 && k == 0) ? -3 : -2;
            if (c == 0 && r < 2 && k < 4) return r * 2 + (k - 2) + 4;
            if (c == 1 && r < 2 && k < 2) return 16777215;
            return c;
        end
        if (kind == 2 && c == 0 && r < 2 && k < 2)
            return -16777216 + ((r == 1 && k == 1) ? 1 : 0);
        if (kind == 2 && c == 0 && r < 2 && k < 4)
            return -16777216;
        return g;
    endfunction

    function automatic int exp_a(int kind, int i);
        int c, pr, pc;
        c  = i / 16;
        pr = (i % 16) / 4;
        pc = i % 4;
        if (kind == 1) begin
            if (i == 0) return -3;
            if (i == 1) return 5;
            if (i == 16) return 16777215;
            return c;
        end
        if (kind == 2 && i == 0) return -16777215;
        if (kind == 2 && i == 1) return -16777216;
        return c * 100 + (2 * pr + 1) * 8 + 2 * pc + 1;
    endfunction

    task automatic run_frame(input int kind, input int nbeats);
        int n;
        n = 0;
        for (int c = 0; c < 64; c++)
            for (int r = 0; r < 8; r++)
                for (int k = 0; k < 8; k++) begin
                    send(1'b0, pix_a(kind, c, r, k));
                    n++;
                    if (n == 1) mode = !mode;
                    if (kind == 0 && n == 9) check("lat_pre", a_out_valid, 0);
                    if (kind == 0 && n == 10) check("lat_post", a_out_valid, 1);
                    if (n == nbeats) return;
                end
    endtask

    task automatic verify_a(input int kind);
        int sz;
        sz = a_qd.size();
        check("a_count", sz, 1024);
        for (int i = 0; i < sz && i < 1024; i++) begin
            check($sformatf("a_data[%0d]", i), a_qd[i], exp_a(kind, i));
            check($sformatf("a_ch[%0d]", i), a_qc[i], i / 16);
            check($sformatf("a_last[%0d]", i), a_ql[i], (i % 16) == 15 ? 1 : 0);
        end
        check("a_fd_count", a_fd_cnt, 1);
        check("a_fd_timing", a_fd_cyc, a_last_hs + 1);
        a_qd.delete();
        a_qc.delete();
        a_ql.delete();
        a_fd_cnt = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int sz;
        rst        = 1'b1;
        mode       = 1'b0;
        a_in_valid = 1'b0;
        a_in_data  = '0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", a_out_valid, 0);
        check("rst_data", a_out_data, 0);
        check("rst_ch", a_out_ch, 0);
        check("rst_last", a_out_last, 0);
        check("rst_fd", a_fd, 0);
        check("rst_ready", a_in_ready, 1);
        check("rst_b_valid", b_out_valid, 0);
        @(posedge clk);
        #1;

        mode   = 1'b0;
        stalls = 0;
        run_frame(0, 4096);
        check("throughput_stalls", stalls, 0);
        repeat (5) @(posedge clk);
        #1;
        verify_a(0);

        mode = 1'b1;
        run_frame(1, 4096);
        repeat (5) @(posedge clk);
        #1;
        verify_a(1);

        mode   = 1'b0;
        bp_en  = 1'b1;
        chk_bp = 1'b1;
        run_frame(2, 4096);
        bp_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_bp = 1'b0;
        verify_a(2);

        mode = 1'b0;
        run_frame(0, 5 * 64 + 37);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_valid", a_out_valid, 0);
        check("midrst_ready", a_in_ready, 1);
        a_qd.delete();
        a_qc.delete();
        a_ql.delete();
        a_fd_cnt = 0;
        mode = 1'b0;
        run_frame(0, 4096);
        repeat (5) @(posedge clk);
        #1;
        verify_a(0);

        mode = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 7; r++)
                for (int k = 0; k < 7; k++)
                    send(1'b1, (r == 6 || k == 6) ? 5000 : c * 100 + r * 10 + k);
        repeat (5) @(posedge clk);
        #1;
        sz = b_qd.size();
        check("b_count", sz, 18);
        for (int i = 0; i < sz && i < 18; i++) begin
            check($sformatf("b_data[%0d]", i), b_qd[i],
                  (i / 9) * 100 + (2 * ((i % 9) / 3) + 1) * 10 + 2 * (i % 3) + 1);
            check($sformatf("b_ch[%0d]", i), b_qc[i], i / 9);
            check($sformatf("b_last[%0d]", i), b_ql[i], (i % 9) == 8 ? 1 : 0);
        end
        check("b_fd_count", b_fd_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
